// File: rtl/mux_seq_pkg.sv
// Shared types and widths for the 16-byte -> 32-bit word-select sequencer.
package mux_seq_pkg;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} seq_state_t;

  localparam int unsigned MUX_BYTE_W = 8;
  localparam int unsigned MUX_GROUPS = 4;
  localparam int unsigned GROUP_W    = $clog2(MUX_GROUPS);
  localparam int unsigned BLOCK_W    = 16 * MUX_BYTE_W;
  localparam int unsigned WORD_W     = 4 * MUX_BYTE_W;

endpackage

// File: rtl/mux_pipeline_seq_ctrl_if.sv
// Block-in / word-out handshake bundle between line buffer, sequencer and PE input bus.
interface mux_pipeline_seq_ctrl_if;
  import mux_seq_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [BLOCK_W-1:0]   in_data;
  logic [GROUP_W-1:0]   in_last_idx;
  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_W-1:0]    out_data;
  logic [GROUP_W-1:0]   out_control;
  logic                 out_last;

  modport master (
    input  in_valid, in_data, in_last_idx, out_ready,
    output in_ready, out_valid, out_data, out_control, out_last
  );

  modport slave (
    output in_valid, in_data, in_last_idx, out_ready,
    input  in_ready, out_valid, out_data, out_control, out_last
  );

endinterface

// File: rtl/MUX_pipeline.sv
// 16-byte to 32-bit word-select MUX: control c picks bytes 4c+3..4c, highest byte on top.
module MUX_pipeline
  import mux_seq_pkg::*;
#(
  parameter int unsigned BYTE_W = MUX_BYTE_W
) (
  input  logic [GROUP_W-1:0]  control,
  input  logic [BYTE_W-1:0]   data_in_0,
  input  logic [BYTE_W-1:0]   data_in_1,
  input  logic [BYTE_W-1:0]   data_in_2,
  input  logic [BYTE_W-1:0]   data_in_3,
  input  logic [BYTE_W-1:0]   data_in_4,
  input  logic [BYTE_W-1:0]   data_in_5,
  input  logic [BYTE_W-1:0]   data_in_6,
  input  logic [BYTE_W-1:0]   data_in_7,
  input  logic [BYTE_W-1:0]   data_in_8,
  input  logic [BYTE_W-1:0]   data_in_9,
  input  logic [BYTE_W-1:0]   data_in_10,
  input  logic [BYTE_W-1:0]   data_in_11,
  input  logic [BYTE_W-1:0]   data_in_12,
  input  logic [BYTE_W-1:0]   data_in_13,
  input  logic [BYTE_W-1:0]   data_in_14,
  input  logic [BYTE_W-1:0]   data_in_15,
  output logic [4*BYTE_W-1:0] data_out
);

  always_comb begin
    data_out = '0;
    unique case (control)
      2'd0: data_out = {data_in_3,  data_in_2,  data_in_1,  data_in_0};
      2'd1: data_out = {data_in_7,  data_in_6,  data_in_5,  data_in_4};
      2'd2: data_out = {data_in_11, data_in_10, data_in_9,  data_in_8};
      2'd3: data_out = {data_in_15, data_in_14, data_in_13, data_in_12};
    endcase
  end

endmodule

// File: rtl/mux_pipeline_seq_ctrl.sv
// Sequencer: registers one 16-byte block per input handshake and walks the MUX select
// 0..last_idx, emitting one 32-bit word per output handshake.
module mux_pipeline_seq_ctrl
  import mux_seq_pkg::*;
#(
  parameter int unsigned BYTE_W     = MUX_BYTE_W,
  parameter int unsigned NUM_GROUPS = MUX_GROUPS,
  parameter bit          ALLOW_B2B  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  mux_pipeline_seq_ctrl_if.master  bus,
  output logic                     busy
);

  // The MUX instance is hard-wired for 8-bit lanes and four words per block.
  if (BYTE_W != MUX_BYTE_W || NUM_GROUPS != MUX_GROUPS) begin : g_bad_cfg
    $error("mux_pipeline_seq_ctrl: BYTE_W must be 8 and NUM_GROUPS must be 4");
  end

  localparam logic [0:0] S_IDLE = IDLE;
  localparam logic [0:0] S_SEND = SEND;

  logic [0:0]          state_q, state_d;
  logic [GROUP_W-1:0]  ctrl_q, ctrl_d;
  logic [GROUP_W-1:0]  last_q;
  logic [BLOCK_W-1:0]  buf_q;
  logic                load_c;
  logic                out_valid_c;
  logic                out_last_c;
  logic                in_ready_c;
  logic                in_fire_c;
  logic                out_fire_c;
  logic [WORD_W-1:0]   word_c;

  // Handshake decode; clear blocks acceptance in its own cycle.
  assign out_valid_c = (state_q == S_SEND);
  assign out_last_c  = out_valid_c && (ctrl_q == last_q);
  assign out_fire_c  = out_valid_c && bus.out_ready;
  assign in_ready_c  = !clear &&
                       ((state_q == S_IDLE) ||
                        (ALLOW_B2B && out_fire_c && out_last_c));
  assign in_fire_c   = bus.in_valid && in_ready_c;

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    load_c  = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
      ctrl_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_fire_c) begin
            load_c  = 1'b1;
            ctrl_d  = '0;
            state_d = S_SEND;
          end
        end
        S_SEND: begin
          if (out_fire_c) begin
            if (!out_last_c) begin
              ctrl_d = ctrl_q + GROUP_W'(1);
            end else begin
              ctrl_d = '0;
              if (in_fire_c) begin
                load_c = 1'b1;
              end else begin
                state_d = S_IDLE;
              end
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          ctrl_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Block buffer and last index change only on an accepted input handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q  <= '0;
      last_q <= '0;
    end else if (load_c) begin
      buf_q  <= bus.in_data;
      last_q <= bus.in_last_idx;
    end
  end

  MUX_pipeline #(
    .BYTE_W (BYTE_W)
  ) u_mux (
    .control    (ctrl_q),
    .data_in_0  (buf_q[  0 +: 8]),
    .data_in_1  (buf_q[  8 +: 8]),
    .data_in_2  (buf_q[ 16 +: 8]),
    .data_in_3  (buf_q[ 24 +: 8]),
    .data_in_4  (buf_q[ 32 +: 8]),
    .data_in_5  (buf_q[ 40 +: 8]),
    .data_in_6  (buf_q[ 48 +: 8]),
    .data_in_7  (buf_q[ 56 +: 8]),
    .data_in_8  (buf_q[ 64 +: 8]),
    .data_in_9  (buf_q[ 72 +: 8]),
    .data_in_10 (buf_q[ 80 +: 8]),
    .data_in_11 (buf_q[ 88 +: 8]),
    .data_in_12 (buf_q[ 96 +: 8]),
    .data_in_13 (buf_q[104 +: 8]),
    .data_in_14 (buf_q[112 +: 8]),
    .data_in_15 (buf_q[120 +: 8]),
    .data_out   (word_c)
  );

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.out_data    = word_c;
  assign bus.out_control = ctrl_q;
  assign bus.out_last    = out_last_c;
  assign busy            = (state_q != S_IDLE);

endmodule
